// File: rtl/bmb_pkg.sv
// Shared definitions for the mem<->BMB bridges: FSM state encoding, BMB
// size encoding and error-counter width.
package bmb_pkg;

  typedef enum logic [1:0] {
    BMB_IDLE = 2'd0,
    BMB_CMD  = 2'd1,
    BMB_RSP  = 2'd2,
    BMB_GNT  = 2'd3
  } bmb_state_e;

  localparam int unsigned ErrCntW = 8;

  // BMB size field is log2 of the transfer size in bytes.
  function automatic logic [2:0] bmb_size(input int unsigned bytes);
    logic [2:0] size;
    case (bytes)
      32'd1:   size = 3'd0;
      32'd2:   size = 3'd1;
      32'd4:   size = 3'd2;
      32'd8:   size = 3'd3;
      32'd16:  size = 3'd4;
      32'd32:  size = 3'd5;
      32'd64:  size = 3'd6;
      default: size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_to_bmb.sv
// Bridges a single-beat mem request/grant port onto a BMB command/response
// bus, with a response timeout and sticky/saturating error reporting.
module mem_to_bmb
  import bmb_pkg::*;
#(
  parameter int unsigned AddrSize      = 32,
  parameter int unsigned DataSize      = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_req,
  output logic                    mem_gnt,
  input  logic [AddrSize-1:0]     mem_addr,
  input  logic [DataSize-1:0]     mem_wdata,
  input  logic [DataSize/8-1:0]   mem_strb,
  input  logic                    mem_we,
  output logic [DataSize-1:0]     mem_rdata,
  output logic                    bmb_cmd_valid,
  input  logic                    bmb_cmd_ready,
  output logic [AddrSize-1:0]     bmb_cmd_payload_address,
  output logic [2:0]              bmb_cmd_payload_size,
  output logic                    bmb_cmd_payload_wr,
  output logic                    bmb_cmd_payload_uncached,
  output logic [DataSize-1:0]     bmb_cmd_payload_data,
  output logic [DataSize/8-1:0]   bmb_cmd_payload_mask,
  output logic                    bmb_cmd_payload_last,
  input  logic                    bmb_rsp_valid,
  input  logic [DataSize-1:0]     bmb_rsp_payload_data,
  input  logic                    bmb_rsp_payload_last,
  input  logic                    bmb_rsp_payload_error,
  output logic                    err_o,
  output logic [ErrCntW-1:0]      err_cnt_o
);

  localparam int unsigned StrbSize = DataSize / 8;
  localparam int unsigned TmoW     = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  bmb_state_e            state_r;
  bmb_state_e            state_s;
  logic [AddrSize-1:0]   addr_r;
  logic [DataSize-1:0]   wdata_r;
  logic [StrbSize-1:0]   mask_r;
  logic                  we_r;
  logic [DataSize-1:0]   rdata_r;
  logic [TmoW-1:0]       tmo_cnt_r;
  logic                  err_r;
  logic [ErrCntW-1:0]    err_cnt_r;
  logic                  timeout_s;
  logic                  err_evt_s;
  logic                  cmd_valid_s;
  logic                  gnt_s;
  logic                  unused_last_s;

  // Single-beat transfers only; the last flag carries no information.
  assign unused_last_s = bmb_rsp_payload_last;

  // A response in the final RSP cycle beats the timeout.
  assign timeout_s = (state_r == BMB_RSP) && !bmb_rsp_valid && (tmo_cnt_r == TmoLast);
  assign err_evt_s = bmb_rsp_valid ? ((state_r != BMB_RSP) || bmb_rsp_payload_error)
                                   : timeout_s;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= BMB_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      BMB_IDLE: begin
        if (mem_req) state_s = BMB_CMD;
        else         state_s = BMB_IDLE;
      end
      BMB_CMD: begin
        if (bmb_cmd_ready) state_s = BMB_RSP;
        else               state_s = BMB_CMD;
      end
      BMB_RSP: begin
        if (bmb_rsp_valid || timeout_s) state_s = BMB_GNT;
        else                            state_s = BMB_RSP;
      end
      BMB_GNT: state_s = BMB_IDLE;
      default: state_s = BMB_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    cmd_valid_s = 1'b0;
    gnt_s       = 1'b0;
    case (state_r)
      BMB_CMD: cmd_valid_s = 1'b1;
      BMB_GNT: gnt_s       = 1'b1;
      default: begin
        cmd_valid_s = 1'b0;
        gnt_s       = 1'b0;
      end
    endcase
  end

  // Command payload capture and read-data return.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_r  <= '0;
      wdata_r <= '0;
      mask_r  <= '0;
      we_r    <= 1'b0;
      rdata_r <= '0;
    end else begin
      if ((state_r == BMB_IDLE) && mem_req) begin
        addr_r  <= mem_addr;
        wdata_r <= mem_wdata;
        mask_r  <= mem_we ? mem_strb : {StrbSize{1'b1}};
        we_r    <= mem_we;
      end
      if ((state_r == BMB_RSP) && bmb_rsp_valid) begin
        rdata_r <= bmb_rsp_payload_data;
      end else if (timeout_s) begin
        rdata_r <= '0;
      end
    end
  end

  // Response timeout counter, cleared whenever the FSM is outside RSP.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt_r <= '0;
    end else if (state_r != BMB_RSP) begin
      tmo_cnt_r <= '0;
    end else if (tmo_cnt_r != TmoLast) begin
      tmo_cnt_r <= tmo_cnt_r + TmoW'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Sticky error flag and saturating error count, one step per cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_r     <= 1'b0;
      err_cnt_r <= '0;
    end else if (err_evt_s) begin
      err_r <= 1'b1;
      if (err_cnt_r != {ErrCntW{1'b1}}) err_cnt_r <= err_cnt_r + ErrCntW'(1);
    end
  end

  assign mem_gnt                  = gnt_s;
  assign mem_rdata                = rdata_r;
  assign bmb_cmd_valid            = cmd_valid_s;
  assign bmb_cmd_payload_address  = addr_r;
  assign bmb_cmd_payload_size     = bmb_size(StrbSize);
  assign bmb_cmd_payload_wr       = we_r;
  assign bmb_cmd_payload_uncached = 1'b1;
  assign bmb_cmd_payload_data     = wdata_r;
  assign bmb_cmd_payload_mask     = mask_r;
  assign bmb_cmd_payload_last     = 1'b1;
  assign err_o                    = err_r;
  assign err_cnt_o                = err_cnt_r;

endmodule

// File: tb/tb_mem_to_bmb.sv
// Self-checking bench for mem_to_bmb: directed vector table, random
// transactions against a transaction-level model, and multi-cycle corners.
module tb_mem_to_bmb;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        mem_req, mem_gnt, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_strb;
  logic        bmb_cmd_valid, bmb_cmd_ready;
  logic [31:0] bmb_cmd_payload_address;
  logic [2:0]  bmb_cmd_payload_size;
  logic        bmb_cmd_payload_wr, bmb_cmd_payload_uncached, bmb_cmd_payload_last;
  logic [63:0] bmb_cmd_payload_data;
  logic [7:0]  bmb_cmd_payload_mask;
  logic        bmb_rsp_valid, bmb_rsp_payload_last, bmb_rsp_payload_error;
  logic [63:0] bmb_rsp_payload_data;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  mem_to_bmb #(.AddrSize(32), .DataSize(64), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .bmb_cmd_valid(bmb_cmd_valid), .bmb_cmd_ready(bmb_cmd_ready),
    .bmb_cmd_payload_address(bmb_cmd_payload_address), .bmb_cmd_payload_size(bmb_cmd_payload_size),
    .bmb_cmd_payload_wr(bmb_cmd_payload_wr), .bmb_cmd_payload_uncached(bmb_cmd_payload_uncached),
    .bmb_cmd_payload_data(bmb_cmd_payload_data), .bmb_cmd_payload_mask(bmb_cmd_payload_mask),
    .bmb_cmd_payload_last(bmb_cmd_payload_last),
    .bmb_rsp_valid(bmb_rsp_valid), .bmb_rsp_payload_data(bmb_rsp_payload_data),
    .bmb_rsp_payload_last(bmb_rsp_payload_last), .bmb_rsp_payload_error(bmb_rsp_payload_error),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic        we;
    int          rdy_dly;
    int          rsp_dly;   // >= TMO means no response at all
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  exp_mask;
    logic [63:0] exp_rdata;
    int          exp_err_inc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          model_cnt = 0;
  logic        model_err = 1'b0;
  logic [63:0] last_rdata = 64'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_err_add(input int k);
    if (k > 0) model_err = 1'b1;
    model_cnt = (model_cnt + k > 255) ? 255 : model_cnt + k;
  endfunction

  // Drives one transaction starting at a negedge with the DUT idle.
  task automatic run_txn(input vec_t v);
    logic [127:0] exp_pl;
    bit           done;
    exp_pl = 128'({v.addr, v.wdata, v.exp_mask, v.we, 3'd3, 1'b1, 1'b1});
    chk("idle_valid", 128'(bmb_cmd_valid), 128'(1'b0));
    mem_req = 1'b1; mem_addr = v.addr; mem_wdata = v.wdata; mem_strb = v.strb; mem_we = v.we;
    @(negedge clk);
    mem_req = 1'b0; mem_addr = ~v.addr; mem_wdata = ~v.wdata; mem_strb = ~v.strb; mem_we = ~v.we;
    for (int i = 0; i <= v.rdy_dly; i++) begin
      chk("cmd_valid", 128'(bmb_cmd_valid), 128'(1'b1));
      chk("cmd_payload", 128'({bmb_cmd_payload_address, bmb_cmd_payload_data, bmb_cmd_payload_mask,
                               bmb_cmd_payload_wr, bmb_cmd_payload_size, bmb_cmd_payload_last,
                               bmb_cmd_payload_uncached}), exp_pl);
      bmb_cmd_ready = (i == v.rdy_dly);
      @(negedge clk);
    end
    bmb_cmd_ready = 1'b0;
    done = 1'b0;
    for (int j = 0; j < TMO && !done; j++) begin
      chk("rsp_wait_gnt", 128'({mem_gnt, bmb_cmd_valid}), 128'(2'b00));
      if (j == v.rsp_dly) begin
        bmb_rsp_valid = 1'b1; bmb_rsp_payload_data = v.rsp_data; bmb_rsp_payload_error = v.rsp_err;
        bmb_rsp_payload_last = 1'($urandom_range(0, 1));
        done = 1'b1;
      end
      @(negedge clk);
      bmb_rsp_valid = 1'b0; bmb_rsp_payload_error = 1'b0; bmb_rsp_payload_data = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    model_err_add(v.exp_err_inc);
    last_rdata = v.exp_rdata;
    chk("gnt", 128'(mem_gnt), 128'(1'b1));
    chk("gnt_rdata", 128'(mem_rdata), 128'(v.exp_rdata));
    chk("gnt_err", 128'({err_o, err_cnt_o}), 128'({model_err, 8'(model_cnt)}));
    @(negedge clk);
    chk("gnt_one_cycle", 128'(mem_gnt), 128'(1'b0));
    chk("rdata_hold", 128'(mem_rdata), 128'(v.exp_rdata));
  endtask

  vec_t table_v[6];
  vec_t rv;
  int   gcnt, last_g;
  logic hs;

  initial begin
    table_v[0] = '{32'h8000_0010, 64'h0, 8'h00, 1'b0, 0, 0,   64'h1122_3344_5566_7788, 1'b0, 8'hFF, 64'h1122_3344_5566_7788, 0};
    table_v[1] = '{32'h8000_0008, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1, 5, 0, 64'h0, 1'b0, 8'hF0, 64'h0, 0};
    table_v[2] = '{32'h8000_0020, 64'h0, 8'h3C, 1'b0, 0, 99,  64'h77, 1'b0, 8'hFF, 64'h0, 1};
    table_v[3] = '{32'h0000_0040, 64'h0, 8'h00, 1'b0, 0, 2,   64'hAA, 1'b1, 8'hFF, 64'hAA, 1};
    table_v[4] = '{32'h0000_0100, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1, 1, 15, 64'hCAFE, 1'b0, 8'h0F, 64'hCAFE, 0};
    table_v[5] = '{32'h0000_0200, 64'h0, 8'h00, 1'b0, 2, 14,  64'h5A5A, 1'b0, 8'hFF, 64'h5A5A, 0};

    rst_ni = 1'b0; mem_req = 1'b0; mem_addr = 32'd0; mem_wdata = 64'd0; mem_strb = 8'd0; mem_we = 1'b0;
    bmb_cmd_ready = 1'b0; bmb_rsp_valid = 1'b0; bmb_rsp_payload_data = 64'd0;
    bmb_rsp_payload_last = 1'b0; bmb_rsp_payload_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({bmb_cmd_valid, mem_gnt, err_o, err_cnt_o}), 128'(11'd0));
    chk("reset_rdata", 128'(mem_rdata), 128'(64'd0));
    chk("reset_payload", 128'({bmb_cmd_payload_address, bmb_cmd_payload_data, bmb_cmd_payload_mask,
                               bmb_cmd_payload_wr}), 128'(0));
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(table_v[i]);

    // Back-to-back: req held high for three transactions, immediate ready/rsp.
    gcnt = 0; last_g = -1; hs = 1'b0; bmb_cmd_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (mem_gnt) begin
        gcnt++;
        if (gcnt > 1) chk("b2b_spacing", 128'(n - last_g), 128'(4));
        chk("b2b_rdata", 128'(mem_rdata), 128'(64'h1234_0000_0000_0000 + 64'(gcnt)));
        last_g = n;
      end
      bmb_rsp_valid = hs;
      bmb_rsp_payload_data = 64'h1234_0000_0000_0000 + 64'(gcnt + 1);
      hs = bmb_cmd_valid & bmb_cmd_ready;
      mem_req = (n <= 8);
      @(negedge clk);
    end
    bmb_cmd_ready = 1'b0; bmb_rsp_valid = 1'b0; mem_req = 1'b0;
    last_rdata = 64'h1234_0000_0000_0003;
    chk("b2b_gnt_count", 128'(gcnt), 128'(3));
    chk("b2b_no_err", 128'({err_o, err_cnt_o}), 128'({model_err, 8'(model_cnt)}));

    for (int k = 0; k < 24; k++) begin
      rv.addr = $urandom; rv.wdata = {$urandom, $urandom}; rv.strb = 8'($urandom_range(0, 255));
      rv.we = 1'($urandom_range(0, 1)); rv.rdy_dly = $urandom_range(0, 3);
      rv.rsp_dly = $urandom_range(0, TMO + 1); rv.rsp_data = {$urandom, $urandom};
      rv.rsp_err = 1'($urandom_range(0, 1));
      rv.exp_mask = rv.we ? rv.strb : 8'hFF;
      rv.exp_rdata = (rv.rsp_dly >= TMO) ? 64'd0 : rv.rsp_data;
      rv.exp_err_inc = ((rv.rsp_dly >= TMO) || rv.rsp_err) ? 1 : 0;
      run_txn(rv);
    end

    // Spurious responses while idle: data ignored, count saturates.
    bmb_rsp_valid = 1'b1; bmb_rsp_payload_data = 64'hFFFF_0000_FFFF_0000;
    repeat (260) @(negedge clk);
    bmb_rsp_valid = 1'b0;
    model_err_add(260);
    chk("sat_cnt", 128'({err_o, err_cnt_o}), 128'({1'b1, 8'd255}));
    chk("spurious_rdata", 128'(mem_rdata), 128'(last_rdata));
    chk("spurious_no_gnt", 128'(mem_gnt), 128'(1'b0));

    // Reset during RSP, then a late response counts as spurious.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0300;
    @(negedge clk);
    mem_req = 1'b0; bmb_cmd_ready = 1'b1;
    @(negedge clk);
    bmb_cmd_ready = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1; model_cnt = 0; model_err = 1'b0;
    chk("rst_mid_clear", 128'({err_o, err_cnt_o, mem_rdata}), 128'(0));
    bmb_rsp_valid = 1'b1; bmb_rsp_payload_data = 64'h55;
    @(negedge clk);
    bmb_rsp_valid = 1'b0;
    model_err_add(1);
    for (int n = 0; n < 6; n++) begin
      chk("rst_mid_no_gnt", 128'({mem_gnt, bmb_cmd_valid}), 128'(2'b00));
      @(negedge clk);
    end
    chk("rst_mid_err", 128'({err_o, err_cnt_o}), 128'({model_err, 8'(model_cnt)}));
    chk("rst_mid_rdata", 128'(mem_rdata), 128'(64'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_to_bmb.md
MEM_TO_BMB -- requirements
Module: mem_to_bmb

Interface
REQ-001 Parameter AddrSize, default 32, address width of both the mem and BMB sides.
REQ-002 Parameter DataSize, default 64, data width; shall be 32 or 64.
REQ-003 Parameter TimeoutCycles, default 1024, maximum number of RSP-state cycles before timeout; shall be at least 2.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low; ports clk_i (in, 1, clock) and rst_ni (in, 1, synchronous active-low reset).
REQ-005 Mem side (requester into this block): mem_req in 1; mem_gnt out 1; mem_addr in AddrSize; mem_wdata in DataSize; mem_strb in DataSize/8; mem_we in 1; mem_rdata out DataSize.
REQ-006 BMB command: bmb_cmd_valid out 1; bmb_cmd_ready in 1; bmb_cmd_payload_address out AddrSize; bmb_cmd_payload_size out 3; bmb_cmd_payload_wr out 1; bmb_cmd_payload_uncached out 1; bmb_cmd_payload_data out DataSize; bmb_cmd_payload_mask out DataSize/8; bmb_cmd_payload_last out 1.
REQ-007 BMB response: bmb_rsp_valid in 1; bmb_rsp_payload_data in DataSize; bmb_rsp_payload_last in 1; bmb_rsp_payload_error in 1.
REQ-008 Status outputs: err_o out 1 (sticky error); err_cnt_o out 8 (saturating error count).

Function
REQ-009 FSM states and transitions:
- IDLE: mem_req=1 -> CMD.
- CMD: bmb_cmd_ready=1 -> RSP.
- RSP: bmb_rsp_valid=1, or timeout -> GNT.
- GNT: -> IDLE unconditionally.
REQ-010 IDLE: mem_req=1 registers mem_addr, mem_wdata, mem_strb and mem_we into the payload registers and enters CMD; bmb_cmd_valid rises the cycle after mem_req is sampled.
REQ-011 CMD: bmb_cmd_valid=1 and payload stays stable until bmb_cmd_ready=1; valid ready in the same cycle completes the command.
REQ-012 Payload mapping:
- address = registered addr, unmodified;
- wr = registered we;
- data = registered wdata;
- mask = registered strb when wr=1, all-ones when wr=0;
- size = log2(DataSize/8);
- last = 1;
- uncached = 1.
REQ-013 RSP: bmb_rsp_valid=1 captures bmb_rsp_payload_data into mem_rdata and enters GNT.
REQ-014 RSP with bmb_rsp_payload_error=1: data still captured; err_o set; err_cnt_o increments.
REQ-015 RSP timeout: counter reset on RSP entry; at TimeoutCycles cycles without bmb_rsp_valid, enter GNT with mem_rdata = 0, err_o set, err_cnt_o incremented.
REQ-016 GNT: mem_gnt=1 for exactly one cycle with mem_rdata valid in that same cycle; mem_req is ignored in GNT.
REQ-017 mem_rdata holds its last value outside GNT.
REQ-018 Back-to-back: mem_req held high through GNT starts the next transaction in the following IDLE cycle; minimum period is 4 cycles with ready and response both immediate.
REQ-019 bmb_rsp_valid outside RSP (spurious) is ignored for data, sets err_o and increments err_cnt_o.
REQ-020 Simultaneous timeout expiry and bmb_rsp_valid: the response wins; no timeout error is recorded.
REQ-021 err_cnt_o saturates at 255.
REQ-022 Multiple error sources in one cycle increment err_cnt_o by 1.
REQ-023 mem_req deasserted while in CMD/RSP does not abort the transaction; GNT is still issued.
REQ-024 bmb_rsp_payload_last is ignored (single-beat only).

Reset
REQ-025 rst_ni=0 at a rising edge forces: FSM to IDLE, bmb_cmd_valid=0, mem_gnt=0, mem_rdata=0, all payload registers 0, timeout counter 0, err_o=0, err_cnt_o=0.
REQ-026 Reset mid-transaction abandons the transaction; no mem_gnt is emitted for it, and a response arriving after reset counts as spurious.

Structure
REQ-027 FSM state enum, BMB size encoding function and error-counter width live in package bmb_pkg, shared with bmb_full_to_mem.
REQ-028 Single flat module; no sub-module (the timeout counter is inline).

Verification
REQ-029 Read: req addr=0x80000010, we=0; ready=1 immediately; rsp data=0x1122334455667788 one cycle later -> cmd address 0x80000010, mask 0xFF, size 3; mem_gnt one cycle with mem_rdata=0x1122334455667788; err_o=0.
REQ-030 Write: addr=0x80000008, wdata=0xDEADBEEF00000000, strb=0xF0; ready delayed 5 cycles -> valid and payload stable for all 6 cycles; wr=1, mask=0xF0; gnt after rsp.
REQ-031 Timeout: TimeoutCycles=16, no rsp -> mem_gnt 16 cycles after RSP entry with mem_rdata=0, err_o=1, err_cnt_o=1.
REQ-032 Error response: rsp error=1, data=0xAA -> mem_rdata=0xAA at gnt, err_o=1, err_cnt_o increments by 1.
REQ-033 Reset during RSP, then rsp_valid arrives -> no mem_gnt; err_o=1, err_cnt_o=1 (spurious response).
REQ-034 Back-to-back reads with mem_req held high for 3 transactions, immediate ready and rsp -> 3 gnt pulses spaced exactly 4 cycles apart.
